// File: rtl/adder_pkg.sv
// Shared types for the pipelined add/subtract unit: operation encoding and
// the payload word carried by every pipeline stage.
package adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

   // Widest operand the payload can carry; the top only uses bits [W:0].
   localparam int unsigned C_MAX_W = 64;

   typedef struct packed {
      logic [C_MAX_W:0] c;
      logic             ovf;
   } payload_t;

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline slot: a valid flag plus payload, updated only when its load
// enable is high. A load with no incoming beat empties the slot.
module adder_pipe_stage
   import adder_pkg::*;
(
   input  logic     i_clk,
   input  logic     i_rst,
   input  logic     i_load,
   input  logic     i_valid,
   input  payload_t i_data,
   output logic     o_valid,
   output payload_t o_data
);

   logic     valid_q;
   payload_t data_q;

   // Payload is only rewritten for real beats, so bubbles do not toggle it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (i_load) begin
         valid_q <= i_valid;
         if (i_valid) begin
            data_q <= i_data;
         end
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined W-bit add/subtract with valid/ready flow control and overflow flag.
// Define ADDER_PIPE_SAT_EN to clamp the result to the W-bit range of the mode.
module adder_pipe
   import adder_pkg::*;
#(
   parameter int G_DATA_WIDTH  = 8,
   parameter int G_PIPE_STAGES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [G_DATA_WIDTH-1:0] i_A,
   input  logic [G_DATA_WIDTH-1:0] i_B,
   input  logic                  i_op,
   input  logic                  i_cin,
   input  logic                  i_signed,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [G_DATA_WIDTH:0] o_C,
   output logic                  o_ovf
);

   localparam int W = G_DATA_WIDTH;
   localparam int N = G_PIPE_STAGES;

   op_t        op;
   logic [W:0] a_ext;
   logic [W:0] b_ext;
   logic [W:0] cin_ext;
   logic [W:0] sum;
   logic [W:0] res;
   logic       ovf;

   always_comb begin
      op      = op_t'(i_op);
      a_ext   = i_signed ? {i_A[W-1], i_A} : {1'b0, i_A};
      b_ext   = i_signed ? {i_B[W-1], i_B} : {1'b0, i_B};
      cin_ext = {{W{1'b0}}, i_cin};
      if (op == OP_SUB) begin
         sum = a_ext - b_ext - cin_ext;
      end else begin
         sum = a_ext + b_ext + cin_ext;
      end
      // Unsigned: bit W is carry-out or borrow. Signed: the top two bits disagree.
      ovf = i_signed ? (sum[W] ^ sum[W-1]) : sum[W];
   end

`ifdef ADDER_PIPE_SAT_EN
   always_comb begin
      res = sum;
      if (ovf) begin
         if (i_signed) begin
            res = sum[W] ? {2'b11, {(W-1){1'b0}}} : {2'b00, {(W-1){1'b1}}};
         end else if (op == OP_SUB) begin
            res = '0;
         end else begin
            res = {1'b0, {W{1'b1}}};
         end
      end
   end
`else
   assign res = sum;
`endif

   payload_t     stage_in;
   logic [N-1:0] load;
   logic [N-1:0] valid;
   payload_t     data [N];

   always_comb begin
      stage_in        = '0;
      stage_in.c[W:0] = res;
      stage_in.ovf    = ovf;
   end

   // Enable chain: a stage may load if it is empty or its successor loads.
   always_comb begin
      load      = '0;
      load[N-1] = !valid[N-1] || i_ready;
      for (int k = N - 2; k >= 0; k--) begin
         load[k] = !valid[k] || load[k+1];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_stage
         logic     stage_vin;
         payload_t stage_din;

         if (gi == 0) begin : g_first
            assign stage_vin = i_valid;
            assign stage_din = stage_in;
         end else begin : g_rest
            assign stage_vin = valid[gi-1];
            assign stage_din = data[gi-1];
         end

         adder_pipe_stage u_stage (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_load  (load[gi]),
            .i_valid (stage_vin),
            .i_data  (stage_din),
            .o_valid (valid[gi]),
            .o_data  (data[gi])
         );
      end
   endgenerate

   logic unused_hi_bits;
   assign unused_hi_bits = ^data[N-1].c[C_MAX_W:W+1];

   assign o_ready = load[0] && !i_rst;
   assign o_valid = valid[N-1];
   assign o_C     = data[N-1].c[W:0];
   assign o_ovf   = data[N-1].ovf;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed and random checks of adder_pipe at W=8, N=2; expectations follow
// ADDER_PIPE_SAT_EN when it is defined for the build.
module tb_adder_pipe;

   localparam int W = 8;
   localparam int N = 2;
`ifdef ADDER_PIPE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk      = 1'b0;
   logic         rst      = 1'b1;
   logic         i_valid  = 1'b0;
   logic         i_ready  = 1'b0;
   logic         i_op     = 1'b0;
   logic         i_cin    = 1'b0;
   logic         i_signed = 1'b0;
   logic [W-1:0] a        = '0;
   logic [W-1:0] b        = '0;
   logic         o_ready;
   logic         o_valid;
   logic         o_ovf;
   logic [W:0]   o_c;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   adder_pipe #(
      .G_DATA_WIDTH  (W),
      .G_PIPE_STAGES (N)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_A      (a),
      .i_B      (b),
      .i_op     (i_op),
      .i_cin    (i_cin),
      .i_signed (i_signed),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_C      (o_c),
      .o_ovf    (o_ovf)
   );

   // Reference from integer arithmetic and range tests.
   function automatic void model(input logic [7:0] va, input logic [7:0] vb,
                                 input logic vop, input logic vcin, input logic vsgn,
                                 output logic [8:0] mc, output logic mo);
      int ai, bi, r, lo, hi;
      logic [31:0] rv;
      ai = int'(va);
      bi = int'(vb);
      if (vsgn && va[7]) ai = ai - 256;
      if (vsgn && vb[7]) bi = bi - 256;
      r  = vop ? (ai - bi - int'(vcin)) : (ai + bi + int'(vcin));
      lo = vsgn ? -128 : 0;
      hi = vsgn ? 127 : 255;
      mo = (r < lo) || (r > hi);
      if (SAT) begin
         if (r < lo) r = lo;
         if (r > hi) r = hi;
      end
      rv = r;
      mc = rv[8:0];
   endfunction

   task automatic test_reset();
      rst     = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b want 0", o_valid); else passed++;
      checks++; if (o_c !== 9'h000) $display("FAIL reset_o_C: got %h want 000", o_c); else passed++;
      checks++; if (o_ovf !== 1'b0) $display("FAIL reset_o_ovf: got %b want 0", o_ovf); else passed++;
      checks++; if (o_ready !== 1'b0) $display("FAIL reset_o_ready: got %b want 0", o_ready); else passed++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (o_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", o_ready); else passed++;
      $display("reset: done");
   endtask

   task automatic test_vector(input string name, input logic [7:0] va, input logic [7:0] vb,
                              input logic vop, input logic vcin, input logic vsgn,
                              input logic [8:0] exp_c, input logic exp_ovf);
      @(negedge clk);
      a = va; b = vb; i_op = vop; i_cin = vcin; i_signed = vsgn;
      i_valid = 1'b1;
      i_ready = 1'b1;
      #1;
      checks++; if (o_ready !== 1'b1) $display("FAIL %s_ready: got %b want 1", name, o_ready); else passed++;
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      #1;
      checks++; if (o_valid !== 1'b0) $display("FAIL %s_early_valid: got %b want 0", name, o_valid); else passed++;
      @(negedge clk);
      #1;
      checks++; if (o_valid !== 1'b1) $display("FAIL %s_latency: got o_valid %b want 1", name, o_valid); else passed++;
      checks++; if (o_c !== exp_c) $display("FAIL %s_C: got %h want %h", name, o_c, exp_c); else passed++;
      checks++; if (o_ovf !== exp_ovf) $display("FAIL %s_ovf: got %b want %b", name, o_ovf, exp_ovf); else passed++;
      $display("vector %s: A=%h B=%h op=%b cin=%b s=%b -> C=%h ovf=%b", name, va, vb, vop, vcin, vsgn, o_c, o_ovf);
   endtask

   task automatic test_directed();
      test_vector("uadd_200_100_c1", 8'd200, 8'd100, 1'b0, 1'b1, 1'b0, SAT ? 9'h0FF : 9'h12D, 1'b1);
      test_vector("sadd_100_100",    8'd100, 8'd100, 1'b0, 1'b0, 1'b1, SAT ? 9'h07F : 9'h0C8, 1'b1);
      test_vector("usub_5_10",       8'd5,   8'd10,  1'b1, 1'b0, 1'b0, SAT ? 9'h000 : 9'h1FB, 1'b1);
      test_vector("ssub_m128_1",     8'h80,  8'h01,  1'b1, 1'b0, 1'b1, SAT ? 9'h180 : 9'h17F, 1'b1);
      test_vector("ssub_3_m4",       8'h03,  8'hFC,  1'b1, 1'b0, 1'b1, 9'h007, 1'b0);
      test_vector("uadd_10_20",      8'd10,  8'd20,  1'b0, 1'b0, 1'b0, 9'h01E, 1'b0);
      test_vector("usub_10_3_b1",    8'd10,  8'd3,   1'b1, 1'b1, 1'b0, 9'h006, 1'b0);
      test_vector("sadd_m1_m1",      8'hFF,  8'hFF,  1'b0, 1'b0, 1'b1, 9'h1FE, 1'b0);
      test_vector("uadd_255_255_c1", 8'hFF,  8'hFF,  1'b0, 1'b1, 1'b0, SAT ? 9'h0FF : 9'h1FF, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int         sent = 0;
      int         recv = 0;
      logic       in_fire, out_fire;
      logic [8:0] held;
      logic [8:0] exp_c [5];
      logic       exp_o [5];
      logic [7:0] src_a [5];
      logic [7:0] src_b [5];
      src_a = '{8'd10, 8'd70, 8'd130, 8'd190, 8'd250};
      src_b = '{8'd5, 8'd35, 8'd65, 8'd95, 8'd125};
      exp_c = '{9'd15, 9'd105, 9'd195, SAT ? 9'd255 : 9'd285, SAT ? 9'd255 : 9'd375};
      exp_o = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      i_op = 1'b0; i_cin = 1'b0; i_signed = 1'b0;
      i_ready = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         i_valid = (sent < 5);
         a = src_a[sent < 5 ? sent : 0];
         b = src_b[sent < 5 ? sent : 0];
         #1;
         if (i_valid && o_ready) begin
            @(posedge clk);
            sent++;
         end
      end
      checks++; if (sent != 2) $display("FAIL bp_accepted: got %0d want 2", sent); else passed++;
      checks++; if (o_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", o_ready); else passed++;
      checks++; if (o_valid !== 1'b1) $display("FAIL bp_valid_stall: got %b want 1", o_valid); else passed++;
      checks++; if (o_c !== exp_c[0]) $display("FAIL bp_head: got %h want %h", o_c, exp_c[0]); else passed++;
      held = o_c;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (o_c !== held || o_valid !== 1'b1) $display("FAIL bp_hold: got %h/%b want %h/1", o_c, o_valid, held); else passed++;
      for (int cyc = 0; cyc < 30 && recv < 5; cyc++) begin
         @(negedge clk);
         i_ready = 1'b1;
         i_valid = (sent < 5);
         a = src_a[sent < 5 ? sent : 0];
         b = src_b[sent < 5 ? sent : 0];
         #1;
         if (cyc == 0) begin
            checks++; if (o_ready !== 1'b1) $display("FAIL bp_full_ready: got %b want 1", o_ready); else passed++;
         end
         in_fire  = i_valid && o_ready;
         out_fire = o_valid && i_ready;
         if (out_fire) begin
            checks++;
            if (o_c !== exp_c[recv] || o_ovf !== exp_o[recv])
               $display("FAIL bp_beat%0d: got %h/%b want %h/%b", recv, o_c, o_ovf, exp_c[recv], exp_o[recv]);
            else passed++;
            $display("backpressure beat %0d: C=%h ovf=%b", recv, o_c, o_ovf);
            recv++;
         end
         @(posedge clk);
         if (in_fire) sent++;
      end
      i_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (recv != 5) $display("FAIL bp_count: got %0d want 5", recv); else passed++;
      checks++; if (o_valid !== 1'b0) $display("FAIL bp_no_dup: got o_valid %b want 0", o_valid); else passed++;
   endtask

   task automatic test_reset_midflight();
      int sent = 0;
      int seen = 0;
      i_ready = 1'b0;
      a = 8'd1; b = 8'd2; i_op = 1'b0; i_cin = 1'b0; i_signed = 1'b0;
      for (int cyc = 0; cyc < 6 && sent < 2; cyc++) begin
         @(negedge clk);
         i_valid = 1'b1;
         #1;
         if (o_ready) begin
            @(posedge clk);
            sent++;
         end
      end
      @(negedge clk);
      i_valid = 1'b0;
      #1;
      checks++; if (o_valid !== 1'b1) $display("FAIL rst_mid_pre_valid: got %b want 1", o_valid); else passed++;
      rst = 1'b1;
      #1;
      checks++; if (o_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", o_valid); else passed++;
      checks++; if (o_c !== 9'h000) $display("FAIL rst_mid_C: got %h want 000", o_c); else passed++;
      checks++; if (o_ready !== 1'b0) $display("FAIL rst_mid_ready: got %b want 0", o_ready); else passed++;
      @(negedge clk);
      rst = 1'b0;
      i_ready = 1'b1;
      #1;
      checks++; if (o_ready !== 1'b1) $display("FAIL rst_mid_release_ready: got %b want 1", o_ready); else passed++;
      repeat (4) begin
         @(negedge clk);
         #1;
         if (o_valid) seen++;
      end
      checks++; if (seen != 0) $display("FAIL rst_mid_stale: got %0d stale beats want 0", seen); else passed++;
      $display("reset midflight: done");
   endtask

   task automatic test_random();
      localparam int BEATS = 400;
      logic [8:0] q_c [$];
      logic       q_o [$];
      int         sent = 0;
      int         recv = 0;
      logic       in_fire, out_fire;
      logic       stall_seen = 1'b0;
      logic [8:0] stall_c = '0;
      logic       stall_o = 1'b0;
      logic [8:0] mc;
      logic       mo;
      for (int cyc = 0; cyc < 5000 && recv < BEATS; cyc++) begin
         @(negedge clk);
         #1;
         if (stall_seen) begin
            checks++;
            if (o_valid !== 1'b1 || o_c !== stall_c || o_ovf !== stall_o)
               $display("FAIL rnd_stall_hold: got %b/%h/%b want 1/%h/%b", o_valid, o_c, o_ovf, stall_c, stall_o);
            else passed++;
         end
         i_ready  = ($urandom_range(0, 3) != 0);
         i_valid  = (sent < BEATS) && ($urandom_range(0, 2) != 0);
         a        = 8'($urandom);
         b        = 8'($urandom);
         i_op     = 1'($urandom);
         i_cin    = 1'($urandom);
         i_signed = 1'($urandom);
         #1;
         in_fire  = i_valid && o_ready;
         out_fire = o_valid && i_ready;
         if (out_fire) begin
            checks++;
            if (q_c.size() == 0) begin
               $display("FAIL rnd_extra_beat: got %h with no beat expected", o_c);
            end else begin
               mc = q_c.pop_front();
               mo = q_o.pop_front();
               if (o_c !== mc || o_ovf !== mo)
                  $display("FAIL rnd_beat%0d: got %h/%b want %h/%b", recv, o_c, o_ovf, mc, mo);
               else passed++;
            end
            recv++;
         end
         stall_seen = o_valid && !i_ready;
         stall_c    = o_c;
         stall_o    = o_ovf;
         if (in_fire) begin
            model(a, b, i_op, i_cin, i_signed, mc, mo);
            q_c.push_back(mc);
            q_o.push_back(mo);
            sent++;
         end
         @(posedge clk);
      end
      i_valid = 1'b0;
      checks++; if (recv != BEATS) $display("FAIL rnd_count: got %0d want %0d", recv, BEATS); else passed++;
      $display("random: %0d beats sent, %0d received", sent, recv);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
